// File: rtl/coin_acceptor.sv
// Coin slot front-end: synchronises and debounces three raw sensors and turns each
// clean insertion into one registered pulse (accepted coin, reject or jam).
module coin_acceptor #(
    parameter int DEBOUNCE   = 4,
    parameter int GAP_CYCLES = 8,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic s5,
    input  logic s10,
    input  logic s20,
    input  logic accept_en,
    output logic c5,
    output logic c10,
    output logic c20,
    output logic coin_reject,
    output logic jam,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        GAP     = 2'd2
    } state_t;

    // Number of set bits in a 3-bit channel vector.
    function automatic logic [1:0] count3(input logic [2:0] v);
        count3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    logic [2:0]       sync1_r;
    logic [2:0]       sync2_r;
    logic [2:0]       stable_r;
    logic [2:0]       rise_r;
    logic [CNT_W-1:0] cnt_r [3];

    state_t           state_r;
    state_t           state_nx_s;
    logic [CNT_W-1:0] gap_r;
    logic [CNT_W-1:0] gap_nx_s;

    logic [1:0]       n_rise_s;
    logic             any_rise_s;
    logic             one_rise_s;

    logic c5_s, c10_s, c20_s, reject_s, jam_s, busy_s;

    // Per-channel synchroniser, debounce counter and rise-event detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r  <= 3'b000;
            sync2_r  <= 3'b000;
            stable_r <= 3'b000;
            rise_r   <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            sync1_r <= {s20, s10, s5};
            sync2_r <= sync1_r;
            rise_r  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == CNT_W'(DEBOUNCE - 1)) begin
                    // Sample has differed for DEBOUNCE cycles: commit it.
                    cnt_r[i]    <= '0;
                    stable_r[i] <= sync2_r[i];
                    rise_r[i]   <= sync2_r[i];
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    assign n_rise_s   = count3(rise_r);
    assign any_rise_s = (n_rise_s != 2'd0);
    assign one_rise_s = (n_rise_s == 2'd1);

    // State register and gap counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            gap_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            gap_r   <= gap_nx_s;
        end
    end

    // Next-state logic; any new rise outside IDLE restarts the release wait.
    always_comb begin
        state_nx_s = state_r;
        gap_nx_s   = gap_r;
        case (state_r)
            IDLE: begin
                if (any_rise_s) begin
                    state_nx_s = RELEASE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RELEASE: begin
                if (any_rise_s) begin
                    state_nx_s = RELEASE;
                end else if (stable_r == 3'b000) begin
                    state_nx_s = GAP;
                    gap_nx_s   = CNT_W'(GAP_CYCLES);
                end else begin
                    state_nx_s = RELEASE;
                end
            end
            GAP: begin
                if (any_rise_s) begin
                    state_nx_s = RELEASE;
                end else begin
                    gap_nx_s = gap_r - CNT_W'(1);
                    if (gap_r == CNT_W'(1)) begin
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = GAP;
                    end
                end
            end
            default: begin
                state_nx_s = IDLE;
                gap_nx_s   = '0;
            end
        endcase
    end

    // Output decode for the next registered output values.
    always_comb begin
        c5_s     = 1'b0;
        c10_s    = 1'b0;
        c20_s    = 1'b0;
        reject_s = 1'b0;
        jam_s    = 1'b0;
        busy_s   = (state_nx_s != IDLE);
        case (state_r)
            IDLE: begin
                if (one_rise_s) begin
                    if (accept_en) begin
                        c5_s  = rise_r[0];
                        c10_s = rise_r[1];
                        c20_s = rise_r[2];
                    end else begin
                        reject_s = 1'b1;
                    end
                end else begin
                    jam_s = any_rise_s;
                end
            end
            RELEASE, GAP: begin
                jam_s = any_rise_s;
            end
            default: begin
                jam_s = 1'b0;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            c5          <= 1'b0;
            c10         <= 1'b0;
            c20         <= 1'b0;
            coin_reject <= 1'b0;
            jam         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            c5          <= c5_s;
            c10         <= c10_s;
            c20         <= c20_s;
            coin_reject <= reject_s;
            jam         <= jam_s;
            busy        <= busy_s;
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: table of single-coin insertions plus
// hand-written bounce, glitch, in-gap jam and reset-while-held sequences.
module tb_coin_acceptor;

    logic clk = 1'b0;
    logic reset;
    logic s5, s10, s20, accept_en;
    logic c5, c10, c20, coin_reject, jam, busy;

    int tests  = 0;
    int failed = 0;

    localparam logic [4:0] E_NONE = 5'b00000;
    localparam logic [4:0] E_C5   = 5'b10000;
    localparam logic [4:0] E_C10  = 5'b01000;
    localparam logic [4:0] E_C20  = 5'b00100;
    localparam logic [4:0] E_REJ  = 5'b00010;
    localparam logic [4:0] E_JAM  = 5'b00001;

    // Pulse appears 7 cycles after first high sample (index 6 from that edge);
    // after release busy stays high for 5 debounce + 1 release + 8 gap edges.
    localparam int PULSE_IDX = 6;
    localparam int FALL_IDLE = 14;

    typedef struct {
        logic [2:0] sens;   // bit0 s5, bit1 s10, bit2 s20
        logic       acc;
        int         hold;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [6];

    coin_acceptor #(.DEBOUNCE(4), .GAP_CYCLES(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .s5(s5), .s10(s10), .s20(s20),
        .accept_en(accept_en), .c5(c5), .c10(c10), .c20(c20),
        .coin_reject(coin_reject), .jam(jam), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic set_sens(input logic [2:0] m);
        s5  = m[0];
        s10 = m[1];
        s20 = m[2];
    endtask

    task automatic tick(input logic [4:0] eo, input logic eb, input int id, input int cyc);
        logic [4:0] got;
        @(posedge clk);
        #1;
        got = {c5, c10, c20, coin_reject, jam};
        tests++;
        if (got !== eo || busy !== eb) begin
            failed++;
            $display("FAIL seq%0d cyc%0d: outputs {c5,c10,c20,rej,jam}=%b busy=%b, expected %b busy=%b",
                     id, cyc, got, busy, eo, eb);
        end
    endtask

    // Hold a coin mask for 'hold' cycles, release it and follow it back to IDLE.
    task automatic run_coin(input logic [2:0] m, input logic acc, input int hold,
                            input logic [4:0] eo, input int id);
        set_sens(m);
        accept_en = acc;
        for (int i = 0; i < hold; i++) begin
            tick((i == PULSE_IDX) ? eo : E_NONE, (i >= PULSE_IDX), id, i);
        end
        set_sens(3'b000);
        for (int j = 0; j <= FALL_IDLE; j++) begin
            tick(E_NONE, (j < FALL_IDLE), id, 100 + j);
        end
    endtask

    initial begin
        vecs[0] = '{sens: 3'b010, acc: 1'b1, hold: 20, exp: E_C10};
        vecs[1] = '{sens: 3'b101, acc: 1'b1, hold: 12, exp: E_JAM};
        vecs[2] = '{sens: 3'b001, acc: 1'b0, hold: 10, exp: E_REJ};
        vecs[3] = '{sens: 3'b001, acc: 1'b1, hold: 10, exp: E_C5};
        vecs[4] = '{sens: 3'b100, acc: 1'b1, hold: 9,  exp: E_C20};
        vecs[5] = '{sens: 3'b111, acc: 1'b0, hold: 8,  exp: E_JAM};

        reset = 1'b1;
        accept_en = 1'b1;
        set_sens(3'b000);
        tick(E_NONE, 1'b0, 0, 0);
        tick(E_NONE, 1'b0, 0, 1);
        reset = 1'b0;
        tick(E_NONE, 1'b0, 0, 2);

        for (int v = 0; v < 6; v++) begin
            run_coin(vecs[v].sens, vecs[v].acc, vecs[v].hold, vecs[v].exp, 10 + v);
        end

        // s20 bounce 1,0,1,0 then solid high: one c20 timed from the solid high.
        accept_en = 1'b1;
        for (int b = 0; b < 4; b++) begin
            s20 = (b % 2 == 0) ? 1'b1 : 1'b0;
            tick(E_NONE, 1'b0, 20, b);
        end
        run_coin(3'b100, 1'b1, 10, E_C20, 21);

        // 3-cycle glitch on s5 is filtered out entirely.
        s5 = 1'b1;
        for (int g = 0; g < 3; g++) tick(E_NONE, 1'b0, 22, g);
        s5 = 1'b0;
        for (int g = 3; g < 15; g++) tick(E_NONE, 1'b0, 22, g);

        // c10 accepted, then s5 inserted during GAP: jam and gap restart.
        set_sens(3'b010);
        for (int i = 0; i < 10; i++) tick((i == PULSE_IDX) ? E_C10 : E_NONE, (i >= PULSE_IDX), 23, i);
        set_sens(3'b000);
        for (int j = 0; j < 18; j++) begin
            if (j == 8) s5 = 1'b1;
            tick((j == 14) ? E_JAM : E_NONE, 1'b1, 23, 100 + j);
        end
        s5 = 1'b0;
        for (int k = 0; k <= FALL_IDLE; k++) tick(E_NONE, (k < FALL_IDLE), 23, 200 + k);

        // s10 held through a 2-cycle reset in RELEASE: re-debounced as a new coin.
        set_sens(3'b010);
        for (int i = 0; i < 10; i++) tick((i == PULSE_IDX) ? E_C10 : E_NONE, (i >= PULSE_IDX), 24, i);
        reset = 1'b1;
        tick(E_NONE, 1'b0, 24, 50);
        tick(E_NONE, 1'b0, 24, 51);
        reset = 1'b0;
        run_coin(3'b010, 1'b1, 10, E_C10, 25);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end stage that sits directly upstream of the vending machine controller and produces its c5/c10/c20 coin inputs. It synchronises and debounces three raw, asynchronous coin-slot sensors. Each clean coin insertion becomes exactly one single-cycle, mutually exclusive pulse. It rejects coins while the controller is not accepting, flags simultaneous or overlapping insertions as jams, and enforces a lockout gap between coins.

Parameters:
DEBOUNCE, 4, consecutive synchronised cycles a sensor must differ from its stable value before the stable value changes (>=1)
GAP_CYCLES, 8, lockout cycles after all sensors return low before the next coin is accepted (>=1)
CNT_W, 8, width of debounce and gap counters; must hold max(DEBOUNCE, GAP_CYCLES)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
s5  input  1  raw 5-unit slot sensor, asynchronous, bouncy
s10  input  1  raw 10-unit slot sensor
s20  input  1  raw 20-unit slot sensor
accept_en  input  1  controller ready to take a coin; sampled in IDLE only
c5  output  1  one-cycle accepted-coin pulse, 5 units
c10  output  1  one-cycle accepted-coin pulse, 10 units
c20  output  1  one-cycle accepted-coin pulse, 20 units
coin_reject  output  1  one-cycle pulse: single coin seen while accept_en=0 (coin to be returned)
jam  output  1  one-cycle pulse: multiple or overlapping coin edges
busy  output  1  high in every state except IDLE

Behaviour:
- Reset, synchronous and active-high:
  - clears all outputs to 0, synchroniser flops, stable values, and counters.
  - FSM goes to IDLE.
  - A sensor held high through reset is re-debounced from stable=0 and treated as a new coin.
- Per channel:
  - 2-flop synchroniser, then debounce counter.
  - The counter clears whenever the synchronised sample equals the stable value.
  - Otherwise it increments; on reaching DEBOUNCE, stable <= sample and the counter clears.
  - A rise event is a 0->1 transition of stable, one cycle wide.
- Latency: a clean raw rise first sampled at edge T produces the output pulse high during the cycle after edge T+DEBOUNCE+2. This is DEBOUNCE+3 cycles; 7 with defaults.
- Glitches shorter than DEBOUNCE synchronised cycles never change stable.
- FSM states:
  - IDLE: busy=0.
    - Exactly one rise event and accept_en=1: pulse the matching cN, go to RELEASE.
    - Exactly one rise event and accept_en=0: pulse coin_reject, go to RELEASE.
    - Two or three rise events in the same cycle: pulse jam, no cN, go to RELEASE.
    - No event: stay.
  - RELEASE: wait until all three stable values are 0, then load the gap counter with GAP_CYCLES and go to GAP.
  - GAP: decrement each cycle; go to IDLE on the cycle the counter reaches 0.
  - In RELEASE or GAP: any rise event pulses jam (at most one jam per cycle) and reloads the RELEASE wait. FSM forced to RELEASE.
- All outputs are registered.
- Invariants:
  - c5, c10, c20, coin_reject, and jam are mutually exclusive.
  - Each is never high two consecutive cycles.
- accept_en is ignored outside IDLE. Dropping it mid-coin does not cancel an already-issued pulse.
- A coin whose sensor stays high forever leaves the FSM in RELEASE (busy=1) indefinitely. No timeout.

Test Plan:
- Reset then clean s10 pulse (high 20 cycles, accept_en=1) -> c10=1 for exactly 1 cycle, 7 cycles after the first high sample. After s10 falls: busy stays 1 for the debounce-fall latency plus 8 gap cycles, then 0. No other output asserts.
- s20 bounce (1,0,1,0 each 1 cycle) then solid high 10 cycles -> a single c20 pulse, timed from the start of the solid high. A 3-cycle isolated glitch on s5 -> no output.
- s5 and s20 rise on the same clock -> jam=1 one cycle, c5=c20=0. FSM returns to IDLE only after both fall plus GAP_CYCLES.
- accept_en=0, s5 coin -> coin_reject=1 one cycle, c5 never asserts. Next coin with accept_en=1 after the gap -> c5 accepted.
- c10 accepted; s5 inserted during GAP -> jam pulse, gap restarts after s5 released. The s5 coin is not accepted.
- s10 held high, reset pulsed for 2 cycles mid-RELEASE -> outputs 0 during reset. c10 pulses again DEBOUNCE+3 cycles after reset deasserts.
